// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb: parametrised integer register file with a per-register
// scoreboard (busy bits) for RAW hazard detection and a post-reset zeroing
// sweep. x0 always reads 0 and is never busy.
// Optional feature: define RISCV_REGFILE_BYPASS_EN for write-to-read forwarding.
module riscv_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic                we,
  input  logic [AW-1:0]       dreg_num,
  input  logic [XLEN-1:0]     dreg_val,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_reg,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_val,
  output logic [NRD-1:0]      rd_busy
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t            state, state_nxt;
  logic [AW-1:0]     sweep_idx;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_set, busy_clr;
  logic              arr_we;
  logic [AW-1:0]     arr_waddr;
  logic [XLEN-1:0]   arr_wdata;
  logic [AW-1:0]     ra;

  // State register, sweep index and the registered ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_idx <= AW'(1);
      ready     <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == RUN);
      if (state == INIT) sweep_idx <= sweep_idx + AW'(1);
    end
  end

  // Leave INIT on the edge that zeroes the last register
  always_comb begin
    state_nxt = state;
    if (state == INIT && sweep_idx == LAST_IDX) state_nxt = RUN;
  end

  // Array write port and scoreboard update requests; traffic ignored during INIT
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = dreg_num;
    arr_wdata = dreg_val;
    busy_set  = '0;
    busy_clr  = '0;
    if (state == INIT) begin
      arr_we    = 1'b1;
      arr_waddr = sweep_idx;
      arr_wdata = '0;
    end else begin
      if (we && dreg_num != '0) begin
        arr_we             = 1'b1;
        busy_clr[dreg_num] = 1'b1;
      end
      if (alloc_en && alloc_reg != '0) busy_set[alloc_reg] = 1'b1;
    end
  end

  // Scoreboard: a same-edge allocation overrides the write-back clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~busy_clr) | busy_set;
  end

  // Register array storage; contents only become known through the sweep
  always_ff @(posedge clk) begin
    if (arr_we) regs[arr_waddr] <= arr_wdata;
  end

  // Combinational read ports, masked to zero outside RUN and for x0
  always_comb begin
    rd_val  = '0;
    rd_busy = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (state == RUN && ra != '0) begin
        rd_val[k*XLEN +: XLEN] = regs[ra];
        rd_busy[k]             = busy[ra];
`ifdef RISCV_REGFILE_BYPASS_EN
        if (we && dreg_num == ra) begin
          rd_val[k*XLEN +: XLEN] = dreg_val;
          rd_busy[k]             = 1'b0;
        end
`else
`endif
      end
    end
  end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Self-checking bench for riscv_regfile_sb: default-parameter instance plus a
// XLEN=64 / NREGS=16 / NRD=2 instance. Expected values go into a scoreboard
// queue as stimulus is driven and are popped and compared by checkOutput.
module tb_riscv_regfile_sb;

`ifdef RISCV_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_READY  = 0;
  localparam int K_VAL    = 1;
  localparam int K_BUSY   = 2;
  localparam int K_READY2 = 3;
  localparam int K_VAL2   = 4;
  localparam int K_BUSY2  = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ready;
  logic         we;
  logic [4:0]   dreg_num;
  logic [31:0]  dreg_val;
  logic         alloc_en;
  logic [4:0]   alloc_reg;
  logic [19:0]  rd_addr;
  logic [127:0] rd_val;
  logic [3:0]   rd_busy;

  logic         rst2_n;
  logic         ready2;
  logic         we2;
  logic [3:0]   dreg2;
  logic [63:0]  val2;
  logic         alloc2_en;
  logic [3:0]   alloc2_reg;
  logic [7:0]   rd2_addr;
  logic [127:0] rd2_val;
  logic [1:0]   rd2_busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          kind;
    int          port;
    logic [63:0] exp;
  } sb_t;

  sb_t   sb_q[$];
  string tag_q[$];

  riscv_regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .we(we), .dreg_num(dreg_num),
    .dreg_val(dreg_val), .alloc_en(alloc_en), .alloc_reg(alloc_reg),
    .rd_addr(rd_addr), .rd_val(rd_val), .rd_busy(rd_busy)
  );

  riscv_regfile_sb #(.XLEN(64), .NREGS(16), .NRD(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .ready(ready2), .we(we2), .dreg_num(dreg2),
    .dreg_val(val2), .alloc_en(alloc2_en), .alloc_reg(alloc2_reg),
    .rd_addr(rd2_addr), .rd_val(rd2_val), .rd_busy(rd2_busy)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectOut(input string tag, input int kind, input int port, input logic [63:0] exp);
    sb_t e;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Drive one cycle of main-instance stimulus at the falling edge, then settle
  task automatic applyStimulus(input logic w, input logic [4:0] d, input logic [31:0] v,
                               input logic a, input logic [4:0] ar,
                               input logic [4:0] p0, input logic [4:0] p1,
                               input logic [4:0] p2, input logic [4:0] p3);
    @(negedge clk);
    we        = w;
    dreg_num  = d;
    dreg_val  = v;
    alloc_en  = a;
    alloc_reg = ar;
    rd_addr   = {p3, p2, p1, p0};
    #1;
  endtask

  task automatic checkOutput;
    sb_t         e;
    string       t;
    logic [63:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      case (e.kind)
        K_READY:  obs = {63'd0, ready};
        K_VAL:    obs = {32'd0, rd_val[e.port*32 +: 32]};
        K_BUSY:   obs = {63'd0, rd_busy[e.port]};
        K_READY2: obs = {63'd0, ready2};
        K_VAL2:   obs = rd2_val[e.port*64 +: 64];
        default:  obs = {63'd0, rd2_busy[e.port]};
      endcase
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("[TB] FAIL %s port%0d: observed %0h expected %0h", t, e.port, obs, e.exp);
      end
    end
  endtask

  task automatic expectPort(input string tag, input int port, input logic [31:0] v, input logic b);
    expectOut({tag, "_val"}, K_VAL, port, {32'd0, v});
    expectOut({tag, "_busy"}, K_BUSY, port, {63'd0, b});
  endtask

  task automatic sweepMain;
    for (int e = 1; e <= 31; e++) begin
      @(posedge clk);
      #1;
      expectOut("sweep_ready", K_READY, 0, {63'd0, (e == 31)});
      checkOutput();
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    we = 0; dreg_num = 0; dreg_val = 0; alloc_en = 0; alloc_reg = 0; rd_addr = 0;
    we2 = 0; dreg2 = 0; val2 = 0; alloc2_en = 0; alloc2_reg = 0; rd2_addr = 0;

    // Reset state
    applyStimulus(1, 5, 32'h1111, 1, 5, 1, 2, 3, 5);
    expectOut("rst_ready", K_READY, 0, 64'd0);
    for (int p = 0; p < 4; p++) expectPort("rst", p, 32'd0, 1'b0);
    checkOutput();

    @(negedge clk);
    rst_n = 1'b1;
    we = 0; alloc_en = 0;
    sweepMain();

    // Every register reads zero after the sweep
    for (int r = 0; r < 8; r++) begin
      applyStimulus(0, 0, 0, 0, 0, 5'(4*r), 5'(4*r+1), 5'(4*r+2), 5'(4*r+3));
      for (int p = 0; p < 4; p++) expectPort("swept", p, 32'd0, 1'b0);
      checkOutput();
    end

    // Write x5, read on port 2
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 6);
    expectPort("x5_wcyc", 2, BYP ? 32'hDEADBEEF : 32'd0, 1'b0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 6);
    expectPort("x5_after", 2, 32'hDEADBEEF, 1'b0);
    expectPort("x0_rd", 0, 32'd0, 1'b0);
    checkOutput();

    // Write and allocate x0: dropped
    applyStimulus(1, 0, 32'h1234, 1, 0, 0, 0, 0, 0);
    expectPort("x0_wcyc", 0, 32'd0, 1'b0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 4; p++) expectPort("x0_after", p, 32'd0, 1'b0);
    checkOutput();

    // Allocate x7, idle, then write x7 with a same-edge re-allocation
    applyStimulus(0, 0, 0, 1, 7, 7, 7, 7, 7);
    expectPort("x7_alloc", 0, 32'd0, 1'b0);
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 7, 7, 7, 7);
      expectPort("x7_idle", 1, 32'd0, 1'b1);
      checkOutput();
    end
    applyStimulus(1, 7, 32'h55, 1, 7, 7, 7, 7, 7);
    expectPort("x7_wcyc", 3, BYP ? 32'h55 : 32'd0, BYP ? 1'b0 : 1'b1);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 7, 7, 7, 7);
    expectPort("x7_realloc", 0, 32'h55, 1'b1);
    checkOutput();
    applyStimulus(1, 7, 32'h56, 0, 0, 7, 7, 7, 7);
    expectPort("x7_w2cyc", 2, BYP ? 32'h56 : 32'h55, BYP ? 1'b0 : 1'b1);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 7, 7, 7, 7);
    expectPort("x7_clr", 2, 32'h56, 1'b0);
    checkOutput();

    // Allocate x9 then write it with all ports reading it
    applyStimulus(0, 0, 0, 1, 9, 9, 9, 9, 9);
    expectPort("x9_alloc", 0, 32'd0, 1'b0);
    checkOutput();
    applyStimulus(1, 9, 32'hA5A5A5A5, 0, 0, 9, 9, 9, 9);
    for (int p = 0; p < 4; p++)
      expectPort("x9_wcyc", p, BYP ? 32'hA5A5A5A5 : 32'd0, BYP ? 1'b0 : 1'b1);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 9, 9, 9, 9);
    for (int p = 0; p < 4; p++) expectPort("x9_after", p, 32'hA5A5A5A5, 1'b0);
    checkOutput();

    // Mixed read of several registers
    applyStimulus(0, 0, 0, 0, 0, 5, 7, 9, 0);
    expectPort("mix", 0, 32'hDEADBEEF, 1'b0);
    expectPort("mix", 1, 32'h56, 1'b0);
    expectPort("mix", 2, 32'hA5A5A5A5, 1'b0);
    expectPort("mix", 3, 32'd0, 1'b0);
    checkOutput();

    // Dirty x3 and leave it busy, then reset mid-traffic
    applyStimulus(1, 3, 32'h77, 0, 0, 3, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 3, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 3, 0, 0, 0);
    expectPort("x3_dirty", 0, 32'h77, 1'b1);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b0;
    we = 1; dreg_num = 3; dreg_val = 32'h99; alloc_en = 1; alloc_reg = 3;
    #1;
    expectOut("midrst_ready", K_READY, 0, 64'd0);
    expectPort("midrst", 0, 32'd0, 1'b0);
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweepMain();
    applyStimulus(0, 0, 0, 0, 0, 3, 5, 7, 9);
    for (int p = 0; p < 4; p++) expectPort("resweep", p, 32'd0, 1'b0);
    checkOutput();

    // Second instance: XLEN=64, NREGS=16, NRD=2
    @(negedge clk);
    rst2_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      #1;
      expectOut("p2_sweep_ready", K_READY2, 0, {63'd0, (e == 15)});
      checkOutput();
    end
    @(negedge clk);
    we2 = 1; dreg2 = 15; val2 = 64'h0123456789ABCDEF; rd2_addr = {4'd15, 4'd0};
    #1;
    expectOut("p2_x15_wcyc", K_VAL2, 1, BYP ? 64'h0123456789ABCDEF : 64'd0);
    checkOutput();
    @(negedge clk);
    we2 = 0; alloc2_en = 1; alloc2_reg = 15;
    #1;
    expectOut("p2_x15_val", K_VAL2, 1, 64'h0123456789ABCDEF);
    expectOut("p2_x15_busy0", K_BUSY2, 1, 64'd0);
    expectOut("p2_x0_val", K_VAL2, 0, 64'd0);
    checkOutput();
    @(negedge clk);
    alloc2_en = 0;
    #1;
    expectOut("p2_x15_busy1", K_BUSY2, 1, 64'd1);
    expectOut("p2_x0_busy", K_BUSY2, 0, 64'd0);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_sb.md
# riscv_regfile_sb

Parametrised integer register file for the RISC-V core, successor to the fixed 32x32, 4-read-port register file. It adds a configurable register width, register count and read-port count. A per-register scoreboard (busy bits) lets the issue stage detect RAW hazards, and a post-reset zeroing sweep guarantees known contents. It sits between decode/issue (reads, allocation) and write-back (writes).

## Interface
- XLEN, default 32: register width in bits.
- NREGS, default 32: number of architectural registers; power of two, 2..64.
- AW, default $clog2(NREGS): register index width.
- NRD, default 4: number of read ports, 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ready  out  1  high once the zeroing sweep is done; registered.
- we  in  1  write-back enable.
- dreg_num  in  AW  write-back register index.
- dreg_val  in  XLEN  write-back data.
- alloc_en  in  1  issue stage marks alloc_reg as having a pending producer.
- alloc_reg  in  AW  register index to mark busy.
- rd_addr  in  NRD*AW  packed read indices; port k is [k*AW +: AW].
- rd_val  out  NRD*XLEN  packed read data, combinational.
- rd_busy  out  NRD  per-port hazard flag, combinational.

## Operation
- Two states: INIT and RUN.
- Reset (rst_n low):
  - State goes to INIT and the sweep index to 1.
  - All busy bits clear; ready=0.
  - Array contents are not reset directly.
- INIT:
  - Each rising edge writes 0 to array[index], then increments index.
  - The edge that writes index NREGS-1 moves the state to RUN and sets ready=1.
  - we and alloc_en are ignored.
  - All rd_val read 0 and all rd_busy read 0.
- RUN:
  - When we=1 and dreg_num!=0: array[dreg_num] <= dreg_val, and busy[dreg_num] clears.
  - When alloc_en=1 and alloc_reg!=0: busy[alloc_reg] sets.
  - Same edge with dreg_num==alloc_reg (nonzero): busy stays set. The new producer wins; the data is still written.
- Register 0:
  - rd_val is always 0 and rd_busy is always 0.
  - Writes and allocations to index 0 are dropped.
- Reads: rd_val[k] = array[rd_addr[k]]; rd_busy[k] = busy[rd_addr[k]]. Both are modified by the bypass below when it is compiled in.
- Any number of ports may read the same index; there are no port conflicts.

## Timing
- Read latency is 0 cycles (combinational from rd_addr and state).
- Write and scoreboard latency is 1 edge: the update is visible after the edge (or the same cycle with bypass).
- The sweep takes NREGS-1 edges after rst_n rises; ready=1 from edge NREGS-1 onward.
- Reset asserted mid-operation:
  - ready drops immediately (asynchronously) and busy bits clear.
  - Contents are undefined until the sweep completes again.
  - Pending writes that cycle are lost.
- Reset values: ready=0, busy=0, so rd_busy=0 and rd_val=0 while not ready.

## Configuration
- RISCV_REGFILE_BYPASS_EN defined (write-to-read forwarding):
  - In RUN, when we=1, dreg_num==rd_addr[k] and rd_addr[k]!=0: rd_val[k]=dreg_val and rd_busy[k]=0 in the same cycle.
- RISCV_REGFILE_BYPASS_EN undefined:
  - rd_val[k] returns the pre-edge array value.
  - rd_busy[k] reflects busy before the edge, so the reader sees busy=1 for the write cycle and the new value one cycle later.

## Test plan
- Reset then release with NREGS=32 -> ready=0 for 31 edges, ready=1 after edge 31; every register reads 0, including registers dirtied before reset.
- RUN: write x5=0xDEADBEEF -> port 2 reading x5 gives 0xDEADBEEF after the edge. Write x0=0x1234 -> x0 still reads 0 and never shows busy.
- Alloc x7, then 3 idle cycles, then write x7=0x55 -> rd_busy=1 for those cycles, 0 after the write edge; the same edge with alloc of x7 again keeps busy=1 and the data reads 0x55.
- Bypass defined: we=1, x9=0xA5A5A5A5, all 4 ports reading x9 -> same cycle rd_val=0xA5A5A5A5, rd_busy=0. Undefined: old value and busy=1 that cycle, new value the next cycle.
- Assert rst_n mid-traffic with x3 busy and x3=0x77 -> ready=0 and rd_busy=0 immediately; after the re-sweep x3 reads 0 and we/alloc_en during INIT have no effect.
- Parameter sweep XLEN=64, NREGS=16, NRD=2 -> sweep takes 15 edges; write and read of x15 is correct; alloc_reg index wrap is never produced (AW=4).
